// File: rtl/load_store_unit.sv
// load_store_unit: execute-to-memory stage of the RV32 core.
// Accepts one load/store per valid/ready handshake, drives the byte-addressed
// data memory from registered outputs, and returns write-back data plus an
// error flag. Halfword loads are always assembled from two LBU byte reads.
// Optional feature macro: MISALIGN_SPLIT_EN -- when defined, misaligned
// SH/SW/LH/LHU/LW are split into sequential byte accesses instead of erroring.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter logic [2:0]  NONE_FUNC = 3'b111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_store_func,
  input  logic [2:0]  req_load_func,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [1:0]  mem_func_in,
  output logic [2:0]  mem_func_out,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;
  localparam logic [1:0] F_SB  = 2'b00;
  localparam logic [1:0] F_SH  = 2'b01;
  localparam logic [1:0] F_SW  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      r_state;
  logic        r_store;
  logic        r_bytewise;
  logic [2:0]  r_lfunc;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_acc;
  logic [1:0]  r_cnt;
  logic [1:0]  r_last;

  logic        w_legal;
  logic        w_misal;
  logic [2:0]  w_nbytes;
  logic        w_range_err;
  logic        w_err;
  logic        w_bytewise;
  logic [1:0]  w_cnt_inc;
  logic [31:0] w_acc_next;
  logic [31:0] w_final;

  assign req_ready = (r_state == S_IDLE);
  assign w_cnt_inc = r_cnt + 2'd1;

  // Decode the incoming request: legality, access width and alignment.
  always_comb begin
    w_legal  = 1'b0;
    w_misal  = 1'b0;
    w_nbytes = 3'd1;
    if (req_store) begin
      case (req_store_func)
        F_SB:    w_legal = 1'b1;
        F_SH:    begin w_legal = 1'b1; w_nbytes = 3'd2; w_misal = req_addr[0]; end
        F_SW:    begin w_legal = 1'b1; w_nbytes = 3'd4; w_misal = (req_addr[1:0] != 2'b00); end
        default: w_legal = 1'b0;
      endcase
    end else begin
      case (req_load_func)
        F_LB, F_LBU: w_legal = 1'b1;
        F_LH, F_LHU: begin w_legal = 1'b1; w_nbytes = 3'd2; w_misal = req_addr[0]; end
        F_LW:        begin w_legal = 1'b1; w_nbytes = 3'd4; w_misal = (req_addr[1:0] != 2'b00); end
        default:     w_legal = 1'b0;
      endcase
    end
  end

  // Every touched byte must lie below MEM_BYTES; address steps wrap at 2^32.
  always_comb begin
    w_range_err = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if ((i < 32'(w_nbytes)) && ((req_addr + i) >= MEM_BYTES))
        w_range_err = 1'b1;
    end
  end

  // Pick error vs. byte-serial handling; halfword loads are always byte-serial.
  always_comb begin
`ifdef MISALIGN_SPLIT_EN
    w_err      = !w_legal || w_range_err;
    w_bytewise = (!req_store && (w_nbytes == 3'd2)) || w_misal;
`else
    w_err      = !w_legal || w_misal || w_range_err;
    w_bytewise = !req_store && (w_nbytes == 3'd2);
`endif
  end

  // Assemble byte-serial load data little-endian and extend on the last byte.
  always_comb begin
    w_acc_next = r_acc | (32'(mem_data_out[7:0]) << {r_cnt, 3'b000});
    if (r_last == 2'd1) begin
      if (r_lfunc == F_LH)
        w_final = {{16{w_acc_next[15]}}, w_acc_next[15:0]};
      else
        w_final = {16'h0000, w_acc_next[15:0]};
    end else begin
      w_final = w_acc_next;
    end
  end

  // Main FSM: IDLE accepts and checks, ACCESS drives memory, RESP holds the result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_store      <= 1'b0;
      r_bytewise   <= 1'b0;
      r_lfunc      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_last       <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_rd       <= '0;
      rsp_err      <= 1'b0;
      mem_we       <= 1'b0;
      mem_func_in  <= '0;
      mem_func_out <= NONE_FUNC;
      mem_address  <= '0;
      mem_data_in  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_store    <= req_store;
            r_bytewise <= w_bytewise;
            r_lfunc    <= req_load_func;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_last     <= 2'(w_nbytes - 3'd1);
            rsp_rd     <= req_rd;
            if (w_err) begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              r_state     <= S_ACCESS;
              rsp_err     <= 1'b0;
              mem_address <= req_addr;
              if (req_store) begin
                mem_we      <= 1'b1;
                mem_func_in <= w_bytewise ? F_SB : req_store_func;
                mem_data_in <= req_wdata;
              end else begin
                mem_func_out <= w_bytewise ? F_LBU : req_load_func;
              end
            end
          end
        end
        S_ACCESS: begin
          if (r_store) begin
            if (!r_bytewise || (r_cnt == r_last)) begin
              mem_we    <= 1'b0;
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              r_cnt       <= w_cnt_inc;
              mem_address <= r_addr + 32'(w_cnt_inc);
              mem_data_in <= r_wdata >> {w_cnt_inc, 3'b000};
            end
          end else if (!r_bytewise) begin
            rsp_rdata    <= mem_data_out;
            mem_func_out <= NONE_FUNC;
            r_state      <= S_RESP;
            rsp_valid    <= 1'b1;
          end else if (r_cnt == r_last) begin
            rsp_rdata    <= w_final;
            mem_func_out <= NONE_FUNC;
            r_state      <= S_RESP;
            rsp_valid    <= 1'b1;
          end else begin
            r_acc       <= w_acc_next;
            r_cnt       <= w_cnt_inc;
            mem_address <= r_addr + 32'(w_cnt_inc);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array data memory model
// and a queue scoreboard of expected responses. Honours MISALIGN_SPLIT_EN.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_store_func;
  logic [2:0]  req_load_func;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic        mem_we;
  logic [1:0]  mem_func_in;
  logic [2:0]  mem_func_out;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  load_store_unit #(.MEM_BYTES(1024), .NONE_FUNC(3'b111)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_store_func(req_store_func), .req_load_func(req_load_func),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_func_in(mem_func_in), .mem_func_out(mem_func_out),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- data memory model ----------------
  logic [7:0]  mem [0:1023];
  logic        mem_clear;
  logic [31:0] a1, a2, a3;
  logic [7:0]  rb0, rb1, rb2, rb3;

  assign a1 = mem_address + 32'd1;
  assign a2 = mem_address + 32'd2;
  assign a3 = mem_address + 32'd3;
  assign rb0 = (mem_address < 32'd1024) ? mem[mem_address[9:0]] : 8'h00;
  assign rb1 = (a1 < 32'd1024) ? mem[a1[9:0]] : 8'h00;
  assign rb2 = (a2 < 32'd1024) ? mem[a2[9:0]] : 8'h00;
  assign rb3 = (a3 < 32'd1024) ? mem[a3[9:0]] : 8'h00;

  always_comb begin
    case (mem_func_out)
      3'b000:  mem_data_out = {{24{rb0[7]}}, rb0};
      3'b001:  mem_data_out = {{16{rb1[7]}}, rb1, rb0};
      3'b010:  mem_data_out = {rb3, rb2, rb1, rb0};
      3'b100:  mem_data_out = {24'h0, rb0};
      3'b101:  mem_data_out = {16'h0, rb1, rb0};
      default: mem_data_out = 32'h0;
    endcase
  end

  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      if (mem_address < 32'd1024) mem[mem_address[9:0]] <= mem_data_in[7:0];
      if (mem_func_in != 2'b00 && a1 < 32'd1024) mem[a1[9:0]] <= mem_data_in[15:8];
      if (mem_func_in == 2'b10 && a2 < 32'd1024) mem[a2[9:0]] <= mem_data_in[23:16];
      if (mem_func_in == 2'b10 && a3 < 32'd1024) mem[a3[9:0]] <= mem_data_in[31:24];
    end
  end

  // ---------------- scoreboard and checking ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [4:0]  rd;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic collect(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_spurious"}, {31'b0, rsp_valid}, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
      chk({tag, "_rd"}, {27'b0, rsp_rd}, {27'b0, e.rd});
    end
  endtask

  task automatic send(input string tag, input logic st, input logic [1:0] sf,
                      input logic [2:0] lf, input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] rd, input logic [31:0] erd, input logic eerr,
                      input int elat, input int ewe);
    int lat;
    int we;
    int n;
    @(negedge clock);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    req_valid = 1'b1; req_store = st; req_store_func = sf; req_load_func = lf;
    req_addr = a; req_wdata = wd; req_rd = rd;
    sbq.push_back('{rdata: erd, err: eerr, rd: rd});
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    we  = 0;
    while (lat < 30) begin
      @(negedge clock);
      lat++;
      if (mem_we) we++;
      if (rsp_valid) break;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_we"}, we, ewe);
    if (rsp_ready && rsp_valid) collect(tag);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  initial begin
    reset = 1'b1; mem_clear = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_store_func = '0; req_load_func = '0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_rd", {27'b0, rsp_rd}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_func_in", {30'b0, mem_func_in}, 32'd0);
    chk("rst_func_out", {29'b0, mem_func_out}, 32'd7);
    chk("rst_address", mem_address, 32'd0);
    chk("rst_data_in", mem_data_in, 32'd0);
    reset = 1'b0; mem_clear = 1'b0;
    @(posedge clock);
    #1;

    // Aligned store/load round trip and byte/half extraction
    send("sw10", 1, SW, LB, 32'h10, 32'hDEADBEEF, 5'd1, 32'h0, 0, 2, 1);
    chk("mem_word10", {mem[10'h13], mem[10'h12], mem[10'h11], mem[10'h10]}, 32'hDEADBEEF);
    send("lw10", 0, SB, LW, 32'h10, 32'h0, 5'd2, 32'hDEADBEEF, 0, 2, 0);
    send("lb13", 0, SB, LB, 32'h13, 32'h0, 5'd3, 32'hFFFFFFDE, 0, 2, 0);
    send("lbu13", 0, SB, LBU, 32'h13, 32'h0, 5'd4, 32'h000000DE, 0, 2, 0);
    send("sb30", 1, SB, LB, 32'h30, 32'hAABBCC55, 5'd5, 32'h0, 0, 2, 1);
    chk("mem_word30", {mem[10'h33], mem[10'h32], mem[10'h31], mem[10'h30]}, 32'h00000055);
    send("lh12", 0, SB, LH, 32'h12, 32'h0, 5'd6, 32'hFFFFDEAD, 0, 3, 0);
    send("lhu10", 0, SB, LHU, 32'h10, 32'h0, 5'd7, 32'h0000BEEF, 0, 3, 0);
    send("sh40", 1, SH, LB, 32'h40, 32'h00008001, 5'd8, 32'h0, 0, 2, 1);
    send("lh40", 0, SB, LH, 32'h40, 32'h0, 5'd9, 32'hFFFF8001, 0, 3, 0);

    // Misaligned accesses
`ifdef MISALIGN_SPLIT_EN
    send("sw21", 1, SW, LB, 32'h21, 32'h11223344, 5'd10, 32'h0, 0, 5, 4);
    chk("mem_word21", {mem[10'h24], mem[10'h23], mem[10'h22], mem[10'h21]}, 32'h11223344);
    send("lw21", 0, SB, LW, 32'h21, 32'h0, 5'd11, 32'h11223344, 0, 5, 0);
    send("lh23", 0, SB, LH, 32'h23, 32'h0, 5'd12, 32'h00001122, 0, 3, 0);
`else
    send("sw21", 1, SW, LB, 32'h21, 32'h11223344, 5'd10, 32'h0, 1, 1, 0);
    chk("mem_word21", {mem[10'h24], mem[10'h23], mem[10'h22], mem[10'h21]}, 32'h0);
    send("lw21", 0, SB, LW, 32'h21, 32'h0, 5'd11, 32'h0, 1, 1, 0);
    send("lh23", 0, SB, LH, 32'h23, 32'h0, 5'd12, 32'h0, 1, 1, 0);
`endif

    // Illegal function codes
    send("ill_ld", 0, SB, 3'b011, 32'h10, 32'h0, 5'd13, 32'h0, 1, 1, 0);
    send("ill_st", 1, 2'b11, LB, 32'h10, 32'h12345678, 5'd14, 32'h0, 1, 1, 0);

    // Range boundaries
    send("lbu3ff", 0, SB, LBU, 32'h3FF, 32'h0, 5'd15, 32'h0, 0, 2, 0);
    send("lhu3fe", 0, SB, LHU, 32'h3FE, 32'h0, 5'd16, 32'h0, 0, 3, 0);
    send("lbu400", 0, SB, LBU, 32'h400, 32'h0, 5'd18, 32'h0, 1, 1, 0);
    send("lbuwrap", 0, SB, LBU, 32'hFFFFFFFF, 32'h0, 5'd19, 32'h0, 1, 1, 0);

    // Out-of-range word with write-back stalled: response held, new request ignored
    rsp_ready = 1'b0;
    send("lw3fe", 0, SB, LW, 32'h3FE, 32'h0, 5'd17, 32'h0, 1, 1, 0);
    req_valid = 1'b1; req_store = 1'b0; req_load_func = LW; req_addr = 32'h10; req_rd = 5'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_err", {31'b0, rsp_err}, 32'd1);
      chk("hold_rdata", rsp_rdata, 32'd0);
      chk("hold_rd", {27'b0, rsp_rd}, 32'd17);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_func_out", {29'b0, mem_func_out}, 32'd7);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    collect("lw3fe_rel");
    @(negedge clock);
    chk("rel_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rel_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clock);
    chk("rel_no_accept", {31'b0, req_ready}, 32'd1);

    // Reset during the ACCESS cycle of a store
    @(negedge clock);
    req_valid = 1'b1; req_store = 1'b1; req_store_func = SW;
    req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_rd = 5'd21;
    @(posedge clock);
    #1 req_valid = 1'b0;
    chk("rst_we_before", {31'b0, mem_we}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("rst_we_async", {31'b0, mem_we}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rstmid_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clock);
    chk("rstmid_no_rsp", {31'b0, rsp_valid}, 32'd0);
    @(posedge clock);
    #1;
    send("lw10_after", 0, SB, LW, 32'h10, 32'h0, 5'd22, 32'hDEADBEEF, 0, 2, 0);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
